// File: rtl/hwpe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_sel_ctrl
// Brief    : Drives hwpe_en/hwpe_sel of the cluster HWPE subsystem and
//            sequences drain + clock-gap before every switch. Optional drain
//            timeout under macro HWPE_SEL_DRAIN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_sel_ctrl #(
    parameter int  MAX_NUM_HWPES  = 4,
    parameter int  ID_WIDTH       = 8,
    parameter int  GATE_CYCLES    = 2,
    parameter int  OUTST_W        = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int SEL_W          = (MAX_NUM_HWPES > 1) ? $clog2(MAX_NUM_HWPES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                reg_req_i,
    output logic                reg_gnt_o,
    input  logic                reg_wen_i,
    input  logic [3:0]          reg_add_i,
    input  logic [31:0]         reg_wdata_i,
    input  logic [ID_WIDTH-1:0] reg_id_i,
    output logic                reg_r_valid_o,
    output logic [31:0]         reg_r_rdata_o,
    output logic [ID_WIDTH-1:0] reg_r_id_o,

    input  logic                busy_i,
    input  logic                cfg_req_i,
    input  logic                cfg_gnt_i,
    input  logic                cfg_r_valid_i,
    output logic                cfg_block_o,

    output logic                hwpe_en_o,
    output logic [SEL_W-1:0]    hwpe_sel_o,
    output logic                switch_done_o
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_SEL    = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS = 2'd2;

    localparam int                c_GATE_W    = $clog2(GATE_CYCLES + 1);
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [OUTST_W-1:0]  c_OUTST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GATE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_pend_en;
    logic [SEL_W-1:0]      r_pend_sel;
    logic                  w_pend_en_nxt;
    logic [SEL_W-1:0]      w_pend_sel_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [OUTST_W-1:0]    r_outst;
    logic [OUTST_W-1:0]    w_outst_nxt;
    logic [c_GATE_W-1:0]   r_gate_cnt;
    logic [7:0]            r_switch_cnt;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_ctrl;
    logic                  w_wr_sel;
    logic                  w_wr_status;
    logic                  w_drained;
    logic                  w_gate_last;
    logic                  w_drain_to;
    logic                  w_timeout_flag;
    logic                  w_in_switch;
    logic                  w_cfg_inc;
    logic                  w_cfg_dec;
    logic [31:0]           w_rdata;
    logic                  w_unused_bits;

    assign reg_gnt_o   = reg_req_i;
    assign w_wr        = reg_req_i & ~reg_wen_i;
    assign w_rd        = reg_req_i &  reg_wen_i;
    assign w_wr_ctrl   = w_wr && (reg_add_i[3:2] == c_ADDR_CTRL);
    assign w_wr_sel    = w_wr && (reg_add_i[3:2] == c_ADDR_SEL);
    assign w_wr_status = w_wr && (reg_add_i[3:2] == c_ADDR_STATUS);

    assign w_pend_en_nxt  = w_wr_ctrl ? reg_wdata_i[0] : r_pend_en;
    assign w_pend_sel_nxt = w_wr_sel  ? reg_wdata_i[SEL_W-1:0] : r_pend_sel;

    assign w_drained   = !busy_i && (r_outst == '0);
    assign w_gate_last = (r_state == ST_GATE) && (r_gate_cnt == c_GATE_LAST);
    assign w_in_switch = (r_state == ST_DRAIN) || (r_state == ST_GATE);

    assign w_unused_bits = ^{reg_wdata_i, reg_add_i};

`ifdef HWPE_SEL_DRAIN_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_drain_cnt;
    logic              r_timeout;

    assign w_drain_to     = (r_state == ST_DRAIN) && (r_drain_cnt == c_TO_LAST);
    assign w_timeout_flag = r_timeout;

    // Counter sits at zero outside DRAIN, so it restarts on every DRAIN entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state != ST_DRAIN) begin
                r_drain_cnt <= '0;
            end else if (!w_drain_to) begin
                r_drain_cnt <= r_drain_cnt + c_TO_W'(1);
            end
            if (w_drain_to && !w_drained) begin
                r_timeout <= 1'b1;
            end else if (w_wr_status && reg_wdata_i[2]) begin
                r_timeout <= 1'b0;
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_drain_to       = 1'b0;
    assign w_timeout_flag   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = hwpe_sel_o;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_sel) begin
                    w_sel_nxt = reg_wdata_i[SEL_W-1:0];
                end
                if (w_wr_ctrl && reg_wdata_i[0]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((w_wr_ctrl || w_wr_sel) &&
                    (!w_pend_en_nxt || (w_pend_sel_nxt != hwpe_sel_o))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained || w_drain_to) begin
                    w_state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                // Same-cycle writes are folded in so the last write always wins.
                if (w_gate_last) begin
                    w_sel_nxt   = w_pend_sel_nxt;
                    w_state_nxt = w_pend_en_nxt ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cfg_inc = cfg_req_i & cfg_gnt_i;
    assign w_cfg_dec = cfg_r_valid_i;

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_cfg_inc && !w_cfg_dec && (r_outst != c_OUTST_MAX)) begin
            w_outst_nxt = r_outst + OUTST_W'(1);
        end else if (!w_cfg_inc && w_cfg_dec && (r_outst != '0)) begin
            w_outst_nxt = r_outst - OUTST_W'(1);
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (reg_add_i[3:2])
            c_ADDR_CTRL:   w_rdata = {31'h0, r_pend_en};
            c_ADDR_SEL:    w_rdata = {{(32-SEL_W){1'b0}}, r_pend_sel};
            c_ADDR_STATUS: w_rdata = {16'h0, r_switch_cnt, 5'h0,
                                      w_timeout_flag, busy_i, w_in_switch};
            default:       w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_en     <= 1'b0;
            r_pend_sel    <= '0;
            r_outst       <= '0;
            r_gate_cnt    <= '0;
            r_switch_cnt  <= 8'h0;
            hwpe_en_o     <= 1'b0;
            hwpe_sel_o    <= '0;
            cfg_block_o   <= 1'b0;
            switch_done_o <= 1'b0;
            reg_r_valid_o <= 1'b0;
            reg_r_rdata_o <= 32'h0;
            reg_r_id_o    <= '0;
        end else begin
            r_pend_en  <= w_pend_en_nxt;
            r_pend_sel <= w_pend_sel_nxt;
            r_outst    <= w_outst_nxt;
            if ((r_state == ST_GATE) && !w_gate_last) begin
                r_gate_cnt <= r_gate_cnt + c_GATE_W'(1);
            end else begin
                r_gate_cnt <= '0;
            end
            if (w_gate_last) begin
                r_switch_cnt <= r_switch_cnt + 8'd1;
            end
            // Outputs are registered from the next state to land on the same cycle.
            hwpe_en_o     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            hwpe_sel_o    <= w_sel_nxt;
            cfg_block_o   <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_GATE) ||
                             (w_outst_nxt == c_OUTST_MAX);
            switch_done_o <= w_gate_last;
            reg_r_valid_o <= reg_req_i;
            reg_r_rdata_o <= w_rd ? w_rdata : 32'h0;
            reg_r_id_o    <= reg_req_i ? reg_id_i : reg_r_id_o;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_sel_ctrl
// Brief    : Self-checking bench for hwpe_sel_ctrl (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_sel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_req;
    logic        reg_gnt;
    logic        reg_wen;
    logic [3:0]  reg_add;
    logic [31:0] reg_wdata;
    logic [7:0]  reg_id;
    logic        reg_r_valid;
    logic [31:0] reg_r_rdata;
    logic [7:0]  reg_r_id;
    logic        busy;
    logic        cfg_req;
    logic        cfg_gnt;
    logic        cfg_r_valid;
    logic        cfg_block;
    logic        hwpe_en;
    logic [1:0]  hwpe_sel;
    logic        switch_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hwpe_sel_ctrl #(
        .MAX_NUM_HWPES (4),
        .ID_WIDTH      (8),
        .GATE_CYCLES   (2),
        .OUTST_W       (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_req_i     (reg_req),
        .reg_gnt_o     (reg_gnt),
        .reg_wen_i     (reg_wen),
        .reg_add_i     (reg_add),
        .reg_wdata_i   (reg_wdata),
        .reg_id_i      (reg_id),
        .reg_r_valid_o (reg_r_valid),
        .reg_r_rdata_o (reg_r_rdata),
        .reg_r_id_o    (reg_r_id),
        .busy_i        (busy),
        .cfg_req_i     (cfg_req),
        .cfg_gnt_i     (cfg_gnt),
        .cfg_r_valid_i (cfg_r_valid),
        .cfg_block_o   (cfg_block),
        .hwpe_en_o     (hwpe_en),
        .hwpe_sel_o    (hwpe_sel),
        .switch_done_o (switch_done)
    );

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  id;
        logic [31:0] exp_rdata;
        logic        exp_en;
        logic [1:0]  exp_sel;
        logic        exp_blk;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic en, input logic [1:0] sel,
                           input logic blk, input logic done);
        chk({name, ".en"},   hwpe_en,     en);
        chk({name, ".sel"},  hwpe_sel,    sel);
        chk({name, ".blk"},  cfg_block,   blk);
        chk({name, ".done"}, switch_done, done);
    endtask

    // Drive one request for a cycle, then check the registered response.
    task automatic reg_access(input string name, input logic wen, input logic [3:0] addr,
                              input logic [31:0] wdata, input logic [7:0] id,
                              input logic [31:0] exp_rdata);
        @(negedge clk);
        reg_req   = 1'b1;
        reg_wen   = wen;
        reg_add   = addr;
        reg_wdata = wdata;
        reg_id    = id;
        #1;
        chk({name, ".gnt"}, reg_gnt, 1'b1);
        @(negedge clk);
        reg_req   = 1'b0;
        reg_wdata = 32'h0;
        chk({name, ".rvalid"}, reg_r_valid, 1'b1);
        chk({name, ".rid"},    reg_r_id,    id);
        chk({name, ".rdata"},  reg_r_rdata, exp_rdata);
    endtask

    initial begin
        int bad;
        rst_n       = 1'b0;
        reg_req     = 1'b0;
        reg_wen     = 1'b0;
        reg_add     = 4'h0;
        reg_wdata   = 32'h0;
        reg_id      = 8'h0;
        busy        = 1'b0;
        cfg_req     = 1'b0;
        cfg_gnt     = 1'b0;
        cfg_r_valid = 1'b0;

        vecs[0]  = '{1'b1, 4'h8, 32'h0000_0000, 8'h11, 32'h0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'h4, 32'h0000_0002, 8'h22, 32'h0, 1'b0, 2'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'h4, 32'h0000_0000, 8'h33, 32'h2, 1'b0, 2'd2, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0000, 8'h44, 32'h0, 1'b0, 2'd2, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0001, 8'h55, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0000, 8'h66, 32'h1, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 4'h4, 32'h0000_0002, 8'h77, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0001, 8'h88, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{1'b0, 4'hC, 32'hFFFF_FFFF, 8'h99, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 4'hC, 32'h0000_0000, 8'hAA, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 4'h8, 32'h0000_0000, 8'hBB, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 4'h8, 32'hFFFF_FFFF, 8'hCC, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[12] = '{1'b1, 4'h8, 32'h0000_0000, 8'hDD, 32'h0, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{1'b1, 4'h4, 32'h0000_0000, 8'hEE, 32'h2, 1'b1, 2'd2, 1'b0};

        repeat (3) tick();
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.rvalid", reg_r_valid, 1'b0);
        chk("reset.rdata",  reg_r_rdata, 32'h0);
        chk("reset.rid",    reg_r_id,    8'h0);
        rst_n = 1'b1;

        // Idle-mode programming, enable, and non-switching accesses.
        for (int i = 0; i < 14; i++) begin
            reg_access($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr,
                       vecs[i].wdata, vecs[i].id, vecs[i].exp_rdata);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_sel,
                    vecs[i].exp_blk, 1'b0);
        end
        tick();
        chk("idle.rvalid_low", reg_r_valid, 1'b0);

        // Switch 2 -> 1 with the subsystem already drained.
        reg_access("sw1.wr", 1'b0, 4'h4, 32'h1, 8'h01, 32'h0);
        chk_out("sw1.t1", 1'b1, 2'd2, 1'b1, 1'b0);
        tick(); chk_out("sw1.t2", 1'b0, 2'd2, 1'b1, 1'b0);
        tick(); chk_out("sw1.t3", 1'b0, 2'd2, 1'b1, 1'b0);
        tick(); chk_out("sw1.t4", 1'b1, 2'd1, 1'b0, 1'b1);
        tick(); chk_out("sw1.t5", 1'b1, 2'd1, 1'b0, 1'b0);
        reg_access("sw1.status", 1'b1, 4'h8, 32'h0, 8'h02, 32'h0000_0100);

        // Switch 1 -> 0 while busy with three outstanding config transactions.
        busy    = 1'b1;
        cfg_req = 1'b1;
        cfg_gnt = 1'b1;
        repeat (3) tick();
        cfg_req = 1'b0;
        cfg_gnt = 1'b0;
        reg_access("sw2.wr", 1'b0, 4'h4, 32'h0, 8'h03, 32'h0);
        chk_out("sw2.drain", 1'b1, 2'd1, 1'b1, 1'b0);
        bad = 0;
        repeat (48) begin
            tick();
            if (!(cfg_block && hwpe_en && !switch_done)) bad++;
        end
        chk("sw2.drain_hold", bad, 0);
        reg_access("sw2.status", 1'b1, 4'h8, 32'h0, 8'h04, 32'h0000_0103);
        busy        = 1'b0;
        cfg_r_valid = 1'b1;
        repeat (2) tick();
        cfg_r_valid = 1'b0;
        repeat (3) tick();
        chk_out("sw2.wait_rvalid", 1'b1, 2'd1, 1'b1, 1'b0);
        cfg_r_valid = 1'b1;
        tick();
        cfg_r_valid = 1'b0;
        chk_out("sw2.n1", 1'b1, 2'd1, 1'b1, 1'b0);
        tick(); chk_out("sw2.n2", 1'b0, 2'd1, 1'b1, 1'b0);
        tick(); chk_out("sw2.n3", 1'b0, 2'd1, 1'b1, 1'b0);
        tick(); chk_out("sw2.n4", 1'b1, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("sw2.n5", 1'b1, 2'd0, 1'b0, 1'b0);

        // Writes during DRAIN: last SEL plus disable wins, ends in IDLE.
        busy = 1'b1;
        reg_access("sw3.sel", 1'b0, 4'h4, 32'h3, 8'h05, 32'h0);
        reg_access("sw3.ctrl", 1'b0, 4'h0, 32'h0, 8'h06, 32'h0);
        chk_out("sw3.t3", 1'b1, 2'd0, 1'b1, 1'b0);
        busy = 1'b0;
        tick(); chk_out("sw3.t4", 1'b0, 2'd0, 1'b1, 1'b0);
        tick(); chk_out("sw3.t5", 1'b0, 2'd0, 1'b1, 1'b0);
        tick(); chk_out("sw3.t6", 1'b0, 2'd3, 1'b0, 1'b1);
        reg_access("sw3.status", 1'b1, 4'h8, 32'h0, 8'h07, 32'h0000_0300);

        // Reset in the middle of a switch.
        reg_access("rst.en", 1'b0, 4'h0, 32'h1, 8'h08, 32'h0);
        chk_out("rst.run", 1'b1, 2'd3, 1'b0, 1'b0);
        busy = 1'b1;
        reg_access("rst.sel", 1'b0, 4'h4, 32'h1, 8'h09, 32'h0);
        rst_n = 1'b0;
        tick();
        chk_out("rst.mid", 1'b0, 2'd0, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        busy  = 1'b0;
        bad   = 0;
        repeat (6) begin
            tick();
            if (switch_done || hwpe_en) bad++;
        end
        chk("rst.no_done", bad, 0);
        reg_access("rst.status", 1'b1, 4'h8, 32'h0, 8'h0A, 32'h0);
        reg_access("rst.selrd",  1'b1, 4'h4, 32'h0, 8'h0B, 32'h0);

        // Outstanding counter saturation and simultaneous inc/dec.
        cfg_req = 1'b1;
        cfg_gnt = 1'b1;
        repeat (20) tick();
        chk("sat.block", cfg_block, 1'b1);
        cfg_r_valid = 1'b1;
        tick();
        chk("sat.both", cfg_block, 1'b1);
        cfg_req = 1'b0;
        cfg_gnt = 1'b0;
        tick();
        chk("sat.dec", cfg_block, 1'b0);
        repeat (13) tick();
        cfg_r_valid = 1'b0;
        tick();
        chk_out("sat.end", 1'b0, 2'd0, 1'b0, 1'b0);

`ifdef HWPE_SEL_DRAIN_TIMEOUT_EN
        // Drain timeout with busy stuck high.
        reg_access("to.en", 1'b0, 4'h0, 32'h1, 8'h0C, 32'h0);
        busy = 1'b1;
        reg_access("to.sel", 1'b0, 4'h4, 32'h2, 8'h0D, 32'h0);
        repeat (15) tick();
        chk_out("to.last_drain", 1'b1, 2'd0, 1'b1, 1'b0);
        tick(); chk_out("to.gate", 1'b0, 2'd0, 1'b1, 1'b0);
        repeat (2) tick();
        chk_out("to.done", 1'b1, 2'd2, 1'b0, 1'b1);
        reg_access("to.status", 1'b1, 4'h8, 32'h0, 8'h0E, 32'h0000_0106);
        reg_access("to.clear",  1'b0, 4'h8, 32'h4, 8'h0F, 32'h0);
        reg_access("to.status2", 1'b1, 4'h8, 32'h0, 8'h10, 32'h0000_0102);
        busy = 1'b0;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
